// File: rtl/neander_pkg.sv
// Shared opcodes and FSM encoding for the Neander/Ahmes accumulator CPU.
package neander_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPER,
        S_READ,
        S_WRITE,
        S_HALT
    } state_t;

    // States that own a memory transaction.
    function automatic logic needs_bus(state_t s);
        return (s == S_FETCH) || (s == S_OPER) || (s == S_READ) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/neander_if.sv
// Memory req/ack port of the Neander core; master = CPU, slave = memory.
interface neander_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/neander_alu.sv
// Combinational accumulator ALU. Carry/SUB path exists only with NEANDER_AHMES_EN.
module neander_alu import neander_pkg::*; #(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef NEANDER_AHMES_EN
    input  logic              c_in,
    output logic              c,
`endif
    output logic [DATA_W-1:0] res,
    output logic              n,
    output logic              z
);

`ifdef NEANDER_AHMES_EN
    logic [DATA_W:0] wide;

    always_comb begin
        res  = a;
        c    = c_in;
        wide = '0;
        case (op)
            OP_LDA: res = b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            // C=1 means no borrow, i.e. a >= b unsigned.
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[DATA_W-1:0];
                c    = ~wide[DATA_W];
            end
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_NOT: res = ~a;
            default: res = a;
        endcase
    end
`else
    always_comb begin
        res = a;
        case (op)
            OP_LDA: res = b;
            OP_ADD: res = a + b;
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_NOT: res = ~a;
            default: res = a;
        endcase
    end
`endif

    assign n = res[DATA_W-1];
    assign z = (res == '0);

endmodule

// File: rtl/neander_core.sv
// Multicycle Neander accumulator CPU with latency-tolerant req/ack memory port.
// Define NEANDER_AHMES_EN to add SUB, JC and the carry flag.
module neander_core import neander_pkg::*; #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    neander_if.master         mem,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, opaddr, opaddr_nxt;
    logic [3:0]        ir, ir_nxt;
    logic [DATA_W-1:0] ac_nxt, alu_res;
    logic              n_q, z_q, n_nxt, z_nxt, alu_n, alu_z;
    logic              req_q, we_q, xfer;

`ifdef NEANDER_AHMES_EN
    logic c_q, c_nxt, alu_c;
`endif

    neander_alu #(.DATA_W(DATA_W)) u_alu (
        .op   (ir),
        .a    (ac),
        .b    (mem.rdata),
`ifdef NEANDER_AHMES_EN
        .c_in (c_q),
        .c    (alu_c),
`endif
        .res  (alu_res),
        .n    (alu_n),
        .z    (alu_z)
    );

    assign xfer = mem.req & mem.ack;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        opaddr_nxt = opaddr;
        ac_nxt     = ac;
        n_nxt      = n_q;
        z_nxt      = z_q;
`ifdef NEANDER_AHMES_EN
        c_nxt      = c_q;
`endif
        case (state)
            S_FETCH: if (xfer) begin
                ir_nxt    = mem.rdata[DATA_W-1 -: 4];
                pc_nxt    = pc + 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_FETCH;
                case (ir)
                    OP_NOT: begin
                        ac_nxt = alu_res;
                        n_nxt  = alu_n;
                        z_nxt  = alu_z;
                    end
                    OP_HLT: state_nxt = S_HALT;
                    OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: state_nxt = S_OPER;
`ifdef NEANDER_AHMES_EN
                    OP_SUB: state_nxt = S_OPER;
                    OP_JC:  if (c_q) state_nxt = S_OPER; else pc_nxt = pc + 1'b1;
`endif
                    // Untaken conditional branch skips its operand word.
                    OP_JN:  if (n_q) state_nxt = S_OPER; else pc_nxt = pc + 1'b1;
                    OP_JZ:  if (z_q) state_nxt = S_OPER; else pc_nxt = pc + 1'b1;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_OPER: if (xfer) begin
                pc_nxt     = pc + 1'b1;
                opaddr_nxt = mem.rdata[ADDR_W-1:0];
                case (ir)
                    // Only taken branches reach S_OPER.
`ifdef NEANDER_AHMES_EN
                    OP_JMP, OP_JN, OP_JZ, OP_JC: begin
`else
                    OP_JMP, OP_JN, OP_JZ: begin
`endif
                        pc_nxt    = mem.rdata[ADDR_W-1:0];
                        state_nxt = S_FETCH;
                    end
                    OP_STA:  state_nxt = S_WRITE;
                    default: state_nxt = S_READ;
                endcase
            end
            S_READ: if (xfer) begin
                ac_nxt    = alu_res;
                n_nxt     = alu_n;
                z_nxt     = alu_z;
`ifdef NEANDER_AHMES_EN
                c_nxt     = alu_c;
`endif
                state_nxt = S_FETCH;
            end
            S_WRITE: if (xfer) state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // req/we are registered from the next state so they stay low in the reset
    // cycle and remain stable across a stalled transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= OP_NOP;
            opaddr <= '0;
            ac     <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b1;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
`ifdef NEANDER_AHMES_EN
            c_q    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            opaddr <= opaddr_nxt;
            ac     <= ac_nxt;
            n_q    <= n_nxt;
            z_q    <= z_nxt;
            req_q  <= needs_bus(state_nxt);
            we_q   <= (state_nxt == S_WRITE);
`ifdef NEANDER_AHMES_EN
            c_q    <= c_nxt;
`endif
        end
    end

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = (state == S_READ || state == S_WRITE) ? opaddr : pc;
    assign mem.wdata = ac;

    assign flag_n = n_q;
    assign flag_z = z_q;
`ifdef NEANDER_AHMES_EN
    assign flag_c = c_q;
`else
    assign flag_c = 1'b0;
`endif
    assign halted = (state == S_HALT);

endmodule
